multi_pulse_gen: RTL and testbench
==================================

// Module: multi_pulse_gen
// PURPOSE
//  NCH-channel debounced edge-to-pulse generator.
//  Successor to the single-channel one-shot, generalised in channel count, debounce depth, output pulse width and per-channel edge mode.
//  Each channel turns a multi-cycle level change on its input into exactly one pulse of PW clk cycles.
//  Sits between raw button/handshake/IRQ lines and the control FSMs of the SPI datapath.
// PARAMETERS
//  NCH   4  number of independent channels (>=1)
//  DEB   4  consecutive cycles a new input level must hold before it is accepted (>=1)
//  PW    1  output pulse width in clk cycles (>=1)
// PORTS
//  clk      in   1      system clock, all logic on posedge
//  rst      in   1      asynchronous reset, active-high
//  din      in   NCH    raw channel inputs
//  mode     in   2*NCH  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  clr_ovf  in   NCH    per-channel sticky overflow clear, sampled on posedge
//  pulse    out  NCH    registered one-shot outputs
//  level    out  NCH    registered debounced level of din
//  ovf      out  NCH    sticky: a qualified edge was dropped
// BEHAVIOUR
//  Reset (async, rst=1): pulse=0, level=0, ovf=0, all counters=0.
//   - level resets to 0, so din held high through reset yields one rising event DEB cycles after release.
//  Debounce, per channel, with counter dcnt of width clog2(DEB):
//   - din==level: dcnt<=0.
//   - din!=level and dcnt<DEB-1: dcnt<=dcnt+1.
//   - din!=level and dcnt==DEB-1: level<=din, dcnt<=0, raise event.
//     - Event is rise if new level is 1, fall if it is 0.
//   - Any glitch shorter than DEB cycles is fully rejected; the count restarts from 0.
//  Latency: din changes before edge k; level and pulse both go high after edge k+DEB-1.
//   - DEB=1 gives a 1-edge response, identical to the legacy one-shot.
//  Qualification: the event counts only if mode selects its direction.
//   - mode=00 ignores all events: no pulse, no ovf.
//   - Debounce and level keep running in every mode.
//  Pulse FSM, per channel, states IDLE / ACTIVE, with counter pcnt of width clog2(PW):
//   - IDLE + qualified event: pulse<=1, pcnt<=PW-1, go ACTIVE.
//   - ACTIVE, pcnt!=0: pcnt<=pcnt-1.
//   - ACTIVE, pcnt==0: pulse<=0, go IDLE.
//     - A back-to-back event may start only from IDLE, so there is at least 1 low cycle between pulses.
//   - ACTIVE + qualified event (including the last high cycle): event dropped, ovf<=1.
//  ovf: set by a drop; cleared by clr_ovf.
//   - Drop and clr_ovf in the same cycle: set wins, ovf stays 1.
//  Mode change mid-pulse: the current pulse completes its full PW; the new mode applies to the next event.
//  Channels are fully independent.
//   - Simultaneous events on different channels each produce their own pulse in the same cycle.
//  Reset asserted mid-pulse or mid-debounce: immediate return to reset values; no partial pulse resumes.
//  Input held constant: at most one pulse per level change, never repeating.
// CONFIGURATION
//  MULTI_PULSE_SYNC_EN defined:
//   - din passes through a 2-flop synchroniser per channel (reset value 0) before debounce.
//   - Every latency above grows by 2 cycles.
//   - Use when din is asynchronous to clk.
//  MULTI_PULSE_SYNC_EN undefined:
//   - din feeds debounce directly; caller guarantees din is synchronous to clk.
// TESTING
//  1. NCH=4, DEB=4, PW=1, mode0=01; din0 0->1 held 10 cycles -> level0 high and pulse0=1 for exactly 1 cycle, 4 edges after change; no further pulses.
//  2. DEB=4, din0 high for 3 cycles then low -> no pulse0, level0 stays 0; then 4-cycle high -> one pulse.
//  3. PW=3, mode1=11; din1 rise, held 6 cycles, fall -> two 3-cycle pulses, one per edge; ovf1=0.
//  4. PW=8, DEB=1, mode2=11; rise then fall 2 cycles later -> one 8-cycle pulse, ovf2=1; clr_ovf2 pulse -> ovf2=0; drop coincident with clr -> ovf2=1.
//  5. mode3=00 with din3 toggling -> pulse3=0, ovf3=0, level3 tracks; rst asserted mid-pulse on ch0 -> all outputs 0 immediately.
//  6. Rebuild with MULTI_PULSE_SYNC_EN, rerun 1 -> pulse0 arrives 2 cycles later, same 1-cycle width.

Source files
------------

// File: rtl/multi_pulse_gen.sv
// rtl/multi_pulse_gen.sv - NCH-channel debounced edge-to-pulse generator
// Optional macro MULTI_PULSE_SYNC_EN inserts a 2-flop input synchroniser per channel.
module multi_pulse_gen #(
  parameter int NCH = 4,
  parameter int DEB = 4,
  parameter int PW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   din,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   clr_ovf,
  output logic [NCH-1:0]   pulse,
  output logic [NCH-1:0]   level,
  output logic [NCH-1:0]   ovf
);
  localparam int DW  = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int PCW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [DW-1:0]  DMAX = DW'(DEB - 1);
  localparam logic [PCW-1:0] PMAX = PCW'(PW - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [NCH-1:0] din_s;

`ifdef MULTI_PULSE_SYNC_EN
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign din_s = sync2;
`else
  assign din_s = din;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DW-1:0]  dcnt;
    logic           lvl;
    logic           evt;
    logic           qual;
    logic [PCW-1:0] pcnt;
    state_t         st;
    logic           pls;
    logic           ov;

    // The event fires on the same edge that commits the new level.
    assign evt  = (din_s[g] != lvl) && (dcnt == DMAX);
    assign qual = evt && (din_s[g] ? mode[2*g] : mode[2*g+1]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dcnt <= '0;
        lvl  <= 1'b0;
      end else if (din_s[g] == lvl) begin
        dcnt <= '0;
      end else if (dcnt != DMAX) begin
        dcnt <= dcnt + DW'(1);
      end else begin
        lvl  <= din_s[g];
        dcnt <= '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st   <= IDLE;
        pls  <= 1'b0;
        pcnt <= '0;
        ov   <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (qual) begin
              pls  <= 1'b1;
              pcnt <= PMAX;
              st   <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (pcnt != '0) begin
              pcnt <= pcnt - PCW'(1);
            end else begin
              pls <= 1'b0;
              st  <= IDLE;
            end
          end
          default: begin
            st  <= IDLE;
            pls <= 1'b0;
          end
        endcase
        // A drop outranks a same-cycle clear.
        if ((st == ACTIVE) && qual) begin
          ov <= 1'b1;
        end else if (clr_ovf[g]) begin
          ov <= 1'b0;
        end
      end
    end

    assign pulse[g] = pls;
    assign level[g] = lvl;
    assign ovf[g]   = ov;
  end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb/tb_multi_pulse_gen.sv - randomized and directed bench for multi_pulse_gen
// Three instances (DEB/PW = 4/1, 4/3, 1/8) share stimulus; a timestamp/window model predicts all.
`timescale 1ns/1ps
module tb_multi_pulse_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [7:0] mode;
  logic [3:0] clr_ovf;
  logic [3:0] pa, la, oa, pb, lb, ob, pc, lc, oc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_pulse_gen #(.NCH(4), .DEB(4), .PW(1)) dut_a (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr_ovf(clr_ovf),
    .pulse(pa), .level(la), .ovf(oa));
  multi_pulse_gen #(.NCH(4), .DEB(4), .PW(3)) dut_b (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr_ovf(clr_ovf),
    .pulse(pb), .level(lb), .ovf(ob));
  multi_pulse_gen #(.NCH(4), .DEB(1), .PW(8)) dut_c (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr_ovf(clr_ovf),
    .pulse(pc), .level(lc), .ovf(oc));

`ifdef MULTI_PULSE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  // Reference model: level flips once the last DEB effective samples all disagree with it;
  // a pulse occupies edges [start, start+PW-1] and the channel is busy through start+PW.
  int         deb_p[3] = '{4, 4, 1};
  int         pw_p[3]  = '{1, 3, 8};
  logic [3:0] raw_q[$];
  logic [3:0] eff_q[$];
  logic [3:0] ep[3], el[3], eo[3];
  int         last_start[3][4];
  int         ecount;

  task automatic model_reset();
    raw_q.delete();
    eff_q.delete();
    ecount = 0;
    for (int i = 0; i < 3; i++) begin
      ep[i] = '0; el[i] = '0; eo[i] = '0;
      for (int c = 0; c < 4; c++) last_start[i][c] = -1000;
    end
  endtask

  task automatic model_step();
    logic [3:0] eff, w;
    bit ev, q;
    ecount++;
    raw_q.push_back(din);
    if (SYNC_LAT != 0) eff = (raw_q.size() > SYNC_LAT) ? raw_q[raw_q.size()-1-SYNC_LAT] : 4'b0;
    else eff = din;
    eff_q.push_back(eff);
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        ev = (eff_q.size() >= deb_p[i]);
        for (int k = 1; k <= deb_p[i] && ev; k++) begin
          w = eff_q[eff_q.size()-k];
          if (w[c] == el[i][c]) ev = 1'b0;
        end
        q = 1'b0;
        if (ev) begin
          el[i][c] = ~el[i][c];
          q = el[i][c] ? mode[2*c] : mode[2*c+1];
        end
        if (q && ecount > last_start[i][c] + pw_p[i]) last_start[i][c] = ecount;
        else if (q) eo[i][c] = 1'b1;
        if (!(q && ecount <= last_start[i][c] + pw_p[i] && ecount != last_start[i][c]))
          if (clr_ovf[c]) eo[i][c] = 1'b0;
        ep[i][c] = (ecount >= last_start[i][c]) && (ecount < last_start[i][c] + pw_p[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  function automatic logic [35:0] obs();
    return {pa, la, oa, pb, lb, ob, pc, lc, oc};
  endfunction

  function automatic logic [35:0] exp_vec();
    return {ep[0], el[0], eo[0], ep[1], el[1], eo[1], ep[2], el[2], eo[2]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; din = '0; mode = '0; clr_ovf = '0;
    model_reset();
    for (int j = 0; j < 3; j++) begin
      tick();
      n_chk++;
      if (obs() !== 36'h0) begin
        n_fail++; $display("FAIL reset cyc=%0d got=%h exp=%h", j, obs(), 36'h0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rise();
    int first = -1;
    int cnt = 0;
    mode = 8'h55;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL rise_idle cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    din[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (la[0] && first < 0) first = j;
      if (pa[0]) cnt++;
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL rise cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    n_chk++;
    if (first != 4 + SYNC_LAT) begin
      n_fail++; $display("FAIL rise_latency got=%0d exp=%0d", first, 4 + SYNC_LAT);
    end
    n_chk++;
    if (cnt != 1) begin
      n_fail++; $display("FAIL rise_width got=%0d exp=1", cnt);
    end
  endtask

  task automatic test_glitch();
    int cnt = 0;
    bit lvl_seen = 1'b0;
    din[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL glitch_fall cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    for (int j = 0; j < 12; j++) begin
      din[0] = (j < 3);
      tick();
      if (pa[0]) cnt++;
      if (la[0]) lvl_seen = 1'b1;
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL glitch cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    n_chk++;
    if (cnt != 0 || lvl_seen) begin
      n_fail++; $display("FAIL glitch_reject got=%0d/%0d exp=0/0", cnt, lvl_seen);
    end
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      din[0] = (j < 4);
      tick();
      if (pa[0]) cnt++;
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL hold4 cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    n_chk++;
    if (cnt != 1) begin
      n_fail++; $display("FAIL hold4_pulse got=%0d exp=1", cnt);
    end
  endtask

  task automatic test_both_edges();
    int cnt = 0;
    mode = 8'hff;
    for (int j = 0; j < 20; j++) begin
      din[1] = (j < 6);
      tick();
      if (pb[1]) cnt++;
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL both cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    n_chk++;
    if (cnt != 6 || ob[1] !== 1'b0) begin
      n_fail++; $display("FAIL both_pulses got=%0d/%b exp=6/0", cnt, ob[1]);
    end
  endtask

  task automatic test_ovf();
    int cnt = 0;
    mode = 8'hff;
    for (int j = 0; j < 14; j++) begin
      din[2] = (j < 2);
      tick();
      if (pc[2]) cnt++;
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_drop cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    n_chk++;
    if (cnt != 8 || oc[2] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got=%0d/%b exp=8/1", cnt, oc[2]);
    end
    clr_ovf = 4'b0100;
    tick();
    clr_ovf = '0;
    n_chk++;
    if (oc[2] !== 1'b0 || obs() !== exp_vec()) begin
      n_fail++; $display("FAIL ovf_clr got=%h exp=%h", obs(), exp_vec());
    end
    din[2] = 1'b1;
    tick();
    din[2] = 1'b0;
    clr_ovf = 4'b0100;
    tick();
    clr_ovf = '0;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_tail cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    n_chk++;
    if (oc[2] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", oc[2]);
    end
  endtask

  task automatic test_mode_off();
    logic [3:0] bad = '0;
    mode = 8'h3f;
    for (int j = 0; j < 40; j++) begin
      if (j % 5 == 0) din[3] = ~din[3];
      tick();
      bad[3] = bad[3] | pa[3] | pb[3] | pc[3] | oa[3] | ob[3] | oc[3];
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL mode_off cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    n_chk++;
    if (bad[3] !== 1'b0) begin
      n_fail++; $display("FAIL mode_off_quiet got=%b exp=0", bad[3]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit seen = 1'b0;
    mode = 8'hff;
    din = '0;
    for (int j = 0; j < 10; j++) tick();
    din[0] = 1'b1;
    for (int j = 0; j < 10 && !seen; j++) begin
      tick();
      seen = pb[0];
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL mid_pulse_start got=0 exp=1");
    end
    #2 rst = 1'b1;
    #1 model_reset();
    n_chk++;
    if (obs() !== 36'h0) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", obs(), 36'h0);
    end
    din = 4'($urandom);
    for (int j = 0; j < 3; j++) tick();
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int k;
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 3);
        din[k] = ~din[k];
      end
      if ($urandom_range(0, 40) == 0) mode = 8'($urandom);
      clr_ovf = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", j, obs(), exp_vec());
      end
    end
    clr_ovf = '0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_both_edges();
    test_ovf();
    test_mode_off();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
